// File: rtl/sync_stream_fifo.sv
// Single-clock valid/ready stream FIFO with arbitrary depth, optional fall-through,
// synchronous flush and fill-level status outputs.
module sync_stream_fifo #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEPTH           = 8,
  parameter bit          FALL_THROUGH    = 1'b0,
  parameter int unsigned ALMOST_FULL_TH  = DEPTH - 1,
  parameter int unsigned ALMOST_EMPTY_TH = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [DATA_WIDTH-1:0]      src_data_i,
  input  logic                       src_valid_i,
  output logic                       src_ready_o,
  output logic [DATA_WIDTH-1:0]      dst_data_o,
  output logic                       dst_valid_o,
  input  logic                       dst_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] usage_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  localparam logic [PtrW-1:0]   PtrMax   = PtrW'(DEPTH - 1);
  localparam logic [CountW-1:0] CountMax = CountW'(DEPTH);
  localparam logic [CountW-1:0] AfTh     = CountW'(ALMOST_FULL_TH);
  localparam logic [CountW-1:0] AeTh     = CountW'(ALMOST_EMPTY_TH);

  if (DEPTH < 1) begin : gen_bad_depth
    $error("sync_stream_fifo: DEPTH must be >= 1");
  end
  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : gen_bad_af_th
    $error("sync_stream_fifo: ALMOST_FULL_TH must be in 1..DEPTH");
  end
  if (ALMOST_EMPTY_TH > DEPTH - 1) begin : gen_bad_ae_th
    $error("sync_stream_fifo: ALMOST_EMPTY_TH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [CountW-1:0]     count_q, count_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic bypass_xfer;
  logic wr_en;
  logic rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CountMax);

  // Ready deliberately ignores dst_ready_i: a full FIFO frees its slot one cycle after a pop.
  assign src_ready_o = !full && !flush_i;

  always_comb begin
    dst_valid_o = !empty && !flush_i;
    dst_data_o  = mem_q[rptr_q];
    if (FALL_THROUGH && empty) begin
      dst_valid_o = src_valid_i && !flush_i;
      dst_data_o  = src_data_i;
    end
  end

  assign push = src_valid_i && src_ready_o;
  assign pop  = dst_valid_o && dst_ready_i;

  // A word that enters and leaves an empty fall-through FIFO in one cycle never touches storage.
  assign bypass_xfer = FALL_THROUGH && empty && push && pop;
  assign wr_en       = push && !bypass_xfer;
  assign rd_en       = pop && !bypass_xfer;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        wptr_d = (wptr_q == PtrMax) ? '0 : wptr_q + 1'b1;
      end
      if (rd_en) begin
        rptr_d = (rptr_q == PtrMax) ? '0 : rptr_q + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !flush_i) begin
      mem_q[wptr_q] <= src_data_i;
    end
  end

  // Status depends on the count register only, so it carries no input-to-output paths.
  assign usage_o        = count_q;
  assign almost_full_o  = (count_q >= AfTh);
  assign almost_empty_o = (count_q <= AeTh);

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q <= CountMax));
  a_no_write_unready : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (!src_ready_o |-> !wr_en));
`endif

endmodule
